// File: rtl/sign_mag_serial_arbiter.sv
// sign_mag_serial_arbiter: round-robin shared bit-serial two's-complement to sign-magnitude converter
module sign_mag_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] val0,
    input  logic             req1,
    input  logic [WIDTH-1:0] val1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_op, r_res;
    logic [WIDTH-2:0] r_sh, w_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_seen, r_id, r_last, r_gnt0, r_gnt1, r_ovf, r_done_id;
    logic             w_any, w_pick1, w_in, w_bit, w_last;

    assign w_any   = req0 | req1;
    // On a tie the requester that did not win last time gets the converter
    assign w_pick1 = req1 & (~req0 | ~r_last);
    assign w_in    = r_op[r_cnt];
    assign w_bit   = w_in ^ (r_op[WIDTH-1] & r_seen);
    assign w_sh    = (WIDTH-1)'({w_bit, r_sh} >> 1);
    assign w_last  = r_cnt == CW'(WIDTH - 2);

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign res     = r_res;
    assign ovf     = r_ovf;
    assign done_id = r_done_id;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)  ? (w_any  ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? (w_last ? DONE  : SHIFT) : IDLE;
    end

    always_comb begin
        busy = r_state != IDLE;
        done = r_state == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= '0;
            r_sh      <= '0;
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            if (r_state == IDLE && w_any) begin
                r_op   <= w_pick1 ? val1 : val0;
                r_id   <= w_pick1;
                r_last <= w_pick1;
                r_gnt0 <= ~w_pick1;
                r_gnt1 <= w_pick1;
                r_cnt  <= '0;
                r_seen <= 1'b0;
            end
            if (r_state == SHIFT) begin
                r_sh   <= w_sh;
                r_seen <= r_seen | w_in;
                r_cnt  <= r_cnt + CW'(1);
                // No 1 anywhere below a set sign bit means the input was the most negative value
                if (w_last) begin
                    r_res     <= {r_op[WIDTH-1], w_sh};
                    r_ovf     <= r_op[WIDTH-1] & ~(r_seen | w_in);
                    r_done_id <= r_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_sign_mag_serial_arbiter.sv
// tb_sign_mag_serial_arbiter: scoreboard bench for the shared sign-magnitude converter
module tb_sign_mag_serial_arbiter;
    localparam int W = 8;

    logic         clk = 0, reset = 1;
    logic         req0 = 0, req1 = 0;
    logic [W-1:0] val0 = 0, val1 = 0;
    logic         gnt0, gnt1, busy, done, done_id, ovf;
    logic [W-1:0] res;

    logic         q0 = 0;
    logic [3:0]   v4 = 0;
    logic         g40, g41, b4, d4, id4, o4;
    logic [3:0]   r4;

    int checks = 0, errors = 0;
    logic [8:0] exp0[$], exp1[$];
    int  cyc = 0, gcyc = 0, ldone = 0, hcount = 0;
    bit  hold_mode = 0;

    sign_mag_serial_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .val0(val0), .req1(req1), .val1(val1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .res(res), .ovf(ovf)
    );

    sign_mag_serial_arbiter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .req0(q0), .val0(v4), .req1(1'b0), .val1(4'h0),
        .gnt0(g40), .gnt1(g41), .busy(b4), .done(d4), .done_id(id4),
        .res(r4), .ovf(o4)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // {ovf, sign, magnitude} from plain integer arithmetic
    function automatic logic [8:0] model(input logic [7:0] v);
        int s;
        logic [31:0] m;
        s = int'($signed(v));
        m = s < 0 ? -s : s;
        return {s == -128, v[7], m[6:0]};
    endfunction

    initial begin : monitor
        bit rs, p0, p1, act, last, gid;
        logic [8:0] e, h;
        act = 0; last = 1; h = 0;
        forever begin
            @(posedge clk);
            cyc++;
            rs = reset; p0 = req0; p1 = req1;
            @(negedge clk);
            if (rs) begin
                chk({gnt0, gnt1, busy, done, done_id, ovf, res} == 0, "reset_outputs",
                    {gnt0, gnt1, busy, done, done_id, ovf, res}, 0);
                act = 0; last = 1; h = 0;
            end else begin
                chk(!(gnt0 && gnt1), "gnt_exclusive", {gnt0, gnt1}, 0);
                if (gnt0 || gnt1) begin
                    gid = gnt1;
                    chk(!act, "gnt_while_busy", act, 0);
                    chk(gid ? p1 : p0, "gnt_unrequested", gid, {p1, p0});
                    if (p0 && p1) chk(gid != last, "round_robin", gid, !last);
                    last = gid; act = 1; gcyc = cyc;
                end
                chk(busy == act, "busy", busy, act);
                if (done) begin
                    chk(!(gnt0 || gnt1), "done_with_gnt", {gnt0, gnt1}, 0);
                    chk(done_id == last, "done_id", done_id, last);
                    chk(cyc - gcyc == W - 1, "done_latency", cyc - gcyc, W - 1);
                    if ((done_id ? exp1.size() : exp0.size()) == 0)
                        chk(0, "unexpected_done", done_id, 0);
                    else begin
                        e = done_id ? exp1.pop_front() : exp0.pop_front();
                        chk(res == e[7:0], "res", res, e[7:0]);
                        chk(ovf == e[8], "ovf", ovf, e[8]);
                    end
                    if (hold_mode && hcount > 0) chk(cyc - ldone == W + 1, "done_spacing", cyc - ldone, W + 1);
                    hcount++;
                    ldone = cyc;
                    h = {ovf, res};
                    act = 0;
                end else begin
                    chk({ovf, res} == h, "result_hold", {ovf, res}, h);
                end
            end
        end
    end

    task automatic serve(input bit a, input bit b, input logic [7:0] va, input logic [7:0] vb);
        int k;
        @(negedge clk);
        val0 = va; val1 = vb; req0 = a; req1 = b;
        if (a) exp0.push_back(model(va));
        if (b) exp1.push_back(model(vb));
        for (k = 0; k < 60 && (req0 || req1 || busy || exp0.size() != 0 || exp1.size() != 0); k++) begin
            @(negedge clk);
            if (gnt0) req0 = 0;
            if (gnt1) req1 = 0;
        end
        if (k >= 60) chk(0, "serve_timeout", k, 60);
    endtask

    task automatic conv4(input logic [3:0] v, input logic [3:0] er, input bit eo);
        int k;
        @(negedge clk);
        v4 = v; q0 = 1;
        for (k = 1; k < 20; k++) begin
            @(negedge clk);
            if (g40) q0 = 0;
            if (d4) break;
        end
        chk(k == 4, "w4_done_cycle", k, 4);
        chk(r4 == er, "w4_res", r4, er);
        chk(o4 == eo, "w4_ovf", o4, eo);
        @(negedge clk);
    endtask

    initial begin : main
        int n, k;
        bit first;
        repeat (3) @(negedge clk);
        reset = 0;

        serve(1, 0, 8'hFB, 8'h00);
        foreach (val0[i]) ;
        serve(1, 0, 8'h2A, 8'h00);
        serve(1, 0, 8'h00, 8'h00);
        serve(1, 0, 8'hFF, 8'h00);
        serve(1, 0, 8'h80, 8'h00);
        serve(0, 1, 8'h00, 8'h01);

        // both held continuously: 0,1,0,1 at a 9-cycle done spacing
        @(negedge clk);
        val0 = 8'h90; val1 = 8'h7F; req0 = 1; req1 = 1;
        repeat (2) begin exp0.push_back(model(8'h90)); exp1.push_back(model(8'h7F)); end
        hold_mode = 1; hcount = 0; n = 0; first = 1;
        for (k = 0; k < 80 && (n < 4 || busy || exp0.size() != 0 || exp1.size() != 0); k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                if (first) chk(gnt0, "held_first_gnt0", gnt1, 0);
                first = 0;
                n++;
                if (n == 4) begin req0 = 0; req1 = 0; end
            end
        end
        chk(n == 4, "held_grants", n, 4);
        hold_mode = 0;

        // req1 alone, req0 arrives mid-conversion and waits for the next IDLE
        @(negedge clk);
        val1 = 8'hC3; req1 = 1; exp1.push_back(model(8'hC3));
        for (k = 0; k < 20 && !gnt1; k++) @(negedge clk);
        req1 = 0;
        repeat (2) @(negedge clk);
        val0 = 8'h05; req0 = 1; exp0.push_back(model(8'h05));
        for (k = 0; k < 30 && !gnt0; k++) @(negedge clk);
        chk(gnt0, "late_req0_granted", gnt0, 1);
        chk(exp1.size() == 0, "req1_served_first", exp1.size(), 0);
        req0 = 0;
        serve(0, 0, 8'h00, 8'h00);

        // reset in cycle 4 of a conversion
        @(negedge clk);
        val0 = 8'h33; req0 = 1; exp0.push_back(model(8'h33));
        for (k = 0; k < 20 && !gnt0; k++) @(negedge clk);
        req0 = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        exp0.delete();
        serve(1, 1, 8'h9C, 8'h64);

        repeat (40)
            serve(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));
        serve(1, 1, 8'h80, 8'h00);

        conv4(4'hD, 4'hB, 0);
        conv4(4'h8, 4'h8, 1);
        conv4(4'h3, 4'h3, 0);

        repeat (2) @(negedge clk);
        chk(exp0.size() + exp1.size() == 0, "queues_drained", exp0.size() + exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/sign_mag_serial_arbiter.md
# sign_mag_serial_arbiter

Bit-serial two's-complement to sign-magnitude converter shared between two requesters through a round-robin arbiter. It sequences one conversion at a time over WIDTH cycles: bits are copied until the first 1, then inverted, and the sign bit is retained. It sits between the counter/accumulator logic and the 7-segment display path, so both count sources go through a single converter.

## Interface
- WIDTH, 8, operand/result width including sign bit; legal values are 2 and up.

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants a conversion; it must hold val0 stable while req0 is high.
- val0  in  WIDTH  requester 0 two's-complement operand.
- req1  in  1  requester 1 request.
- val1  in  WIDTH  requester 1 operand.
- gnt0  out  1  one-cycle pulse: the val0 operand has been captured.
- gnt1  out  1  one-cycle pulse: the val1 operand has been captured.
- busy  out  1  high while a conversion is in SHIFT or DONE.
- done  out  1  one-cycle pulse: res/ovf/done_id are valid.
- done_id  out  1  the requester that owns the current result (0 or 1).
- res  out  WIDTH  sign-magnitude result: res[WIDTH-1] is the sign, res[WIDTH-2:0] is the magnitude.
- ovf  out  1  the input was -2^(WIDTH-1); the magnitude is not representable.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE**
  - req0/req1 are sampled only in IDLE.
  - If any req is high at an edge: select a winner, latch its operand and the winner id, pulse its gnt in the next cycle, clear count and seen_one, and go to SHIFT.
  - If no req is high, stay in IDLE.
- **Arbitration**
  - Round-robin pointer last_id.
  - If both requests are high, grant the one that is not last_id. If only one is high, grant it.
  - last_id is updated on every grant. Reset value is last_id=1, so req0 wins first.
- **SHIFT**
  - One bit per cycle, bit index = count, for count 0 to WIDTH-2.
  - Sign 0: out bit = in bit.
  - Sign 1: out bit = seen_one ? ~in bit : in bit; then seen_one |= in bit.
  - The out bit is shifted into an internal shift register.
  - When count==WIDTH-2: on that edge, load res = {sign, shifted magnitude}, set ovf = sign & ~seen_one_final, set done_id, and go to DONE.
- **DONE**
  - done=1 for exactly one cycle, then return to IDLE.
- res, ovf and done_id hold their values until the next entry into DONE. They never change during SHIFT.
- Arithmetic cases:
  - Positive inputs pass through unchanged.
  - 0 → 0 with ovf=0.
  - -2^(WIDTH-1) → res = sign 1 with magnitude 0, and ovf=1.
- A request that is dropped before being sampled in IDLE is ignored. A request still high when the FSM re-enters IDLE starts a new conversion. Requesters must deallocate req on seeing gnt.
- Reset mid-conversion: abort immediately, no done pulse, all outputs go to reset values, last_id=1.

## Timing
- Reset values: gnt0=gnt1=0, busy=0, done=0, done_id=0, res=0, ovf=0.
- Let E0 be the accepting edge in IDLE. Cycles are counted after E0:
  - gnt and busy are high in cycle 1.
  - SHIFT runs in cycles 1 to WIDTH-1.
  - done is high in cycle WIDTH (8 for the default).
  - IDLE is cycle WIDTH+1.
- Earliest next acceptance is at the end of cycle WIDTH+1, giving a throughput of one conversion per WIDTH+1 cycles.
- busy is high from cycle 1 through cycle WIDTH inclusive.
- gnt0 and gnt1 are never high together. done never coincides with gnt.

## Test plan
- Reset, then req0=1 with val0=0xFB (-5) → gnt0 in cycle 1; done in cycle 8 with res=0x85, done_id=0, ovf=0; busy low in cycle 9.
- Single requests: 0x2A→0x2A; 0x00→0x00; 0xFF→0x81; 0x80→0x80 with ovf=1. Each done pulse lasts exactly one cycle, and res holds between done pulses.
- req0 and req1 held continuously, val0=0x90, val1=0x7F → grants alternate 0,1,0,1. Results are 0xF0 (id 0) and 0x7F (id 1), with done spacing of 9 cycles.
- req1 alone raised first, then req0 raised mid-conversion → req1 is served, then req0 is granted in the next IDLE. A req1 dropped before IDLE is not serviced again.
- reset asserted in cycle 4 of a conversion → no done; all outputs 0 on the next cycle. Then both requests are raised → gnt0 first.
- WIDTH=4: val0=0xD (-3) → res=0xB with done in cycle 4. val0=0x8 → res=0x8 with ovf=1.
